// File: rtl/lcd_refresh_driver.sv
`default_nettype none
// ============================================================================
// Module   : lcd_refresh_driver
// Function : Initialises an HD44780-style 16x2 LCD, then rewrites both lines
//            forever from a combinational character source addressed by index.
// Revision : 1.0
// ============================================================================
module lcd_refresh_driver #(
    parameter int POWERUP_WAIT = 750000,
    parameter int STEP_CYCLES  = 2500,
    parameter int CLEAR_WAIT   = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] char_in,
    output logic [4:0] index,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_on,
    output logic       lcd_blon,
    output logic       frame_done
);
    localparam int MAX_A = (POWERUP_WAIT > STEP_CYCLES) ? POWERUP_WAIT : STEP_CYCLES;
    localparam int MAX_P = (MAX_A > CLEAR_WAIT) ? MAX_A : CLEAR_WAIT;
    localparam int CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CW-1:0] C_PWR_LAST  = CW'(POWERUP_WAIT - 1);
    localparam logic [CW-1:0] C_STEP_LAST = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] C_CLR_LAST  = CW'(CLEAR_WAIT - 1);

    typedef enum logic [2:0] {
        ST_PWRUP, ST_INIT, ST_LINE1, ST_SETLINE2, ST_LINE2, ST_SETLINE1
    } state_t;

    typedef enum logic [2:0] {
        PH_FETCH, PH_SETUP, PH_PULSE, PH_HOLD, PH_CLRWAIT
    } phase_t;

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    init_idx_q, init_idx_d;
    logic [4:0]    index_q, index_d;
    logic [7:0]    data_q, data_d;
    logic          rs_q, rs_d;
    logic          en_q, en_d;
    logic          done_q, done_d;
    logic [7:0]    w_cmd;
    logic          w_step_last;
    logic          w_is_char;

    function automatic logic [7:0] f_hex_ascii(input logic [7:0] c);
        if (c < 8'h0A)
            return c + 8'h30;
        else if (c < 8'h10)
            return c + 8'h37;
        else
            return c;
    endfunction

    always_comb begin
        w_cmd = 8'h80;
        case (state_q)
            ST_INIT: begin
                case (init_idx_q)
                    3'd0:    w_cmd = 8'h38;
                    3'd1:    w_cmd = 8'h0C;
                    3'd2:    w_cmd = 8'h01;
                    3'd3:    w_cmd = 8'h06;
                    default: w_cmd = 8'h80;
                endcase
            end
            ST_SETLINE2: w_cmd = 8'hC0;
            default:     w_cmd = 8'h80;
        endcase
    end

    assign w_step_last = (cnt_q == C_STEP_LAST);
    assign w_is_char   = (state_q == ST_LINE1) || (state_q == ST_LINE2);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        init_idx_d = init_idx_q;
        index_d    = index_q;
        data_d     = data_q;
        rs_d       = rs_q;
        if (state_q == ST_PWRUP) begin
            if (cnt_q == C_PWR_LAST) begin
                state_d = ST_INIT;
                phase_d = PH_FETCH;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            case (phase_q)
                PH_FETCH: begin
                    phase_d = PH_SETUP;
                    cnt_d   = '0;
                    data_d  = w_is_char ? f_hex_ascii(char_in) : w_cmd;
                    rs_d    = w_is_char;
                end
                PH_SETUP, PH_PULSE: begin
                    if (w_step_last) begin
                        phase_d = (phase_q == PH_SETUP) ? PH_PULSE : PH_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PH_HOLD: begin
                    if (!w_step_last) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        cnt_d   = '0;
                        phase_d = PH_FETCH;
                        case (state_q)
                            ST_INIT: begin
                                if (init_idx_q == 3'd4) begin
                                    state_d = ST_LINE1;
                                    index_d = 5'd0;
                                end else begin
                                    init_idx_d = init_idx_q + 3'd1;
                                    // Clear-display needs extra settling time before the next command.
                                    if (init_idx_q == 3'd2 && CLEAR_WAIT > 0)
                                        phase_d = PH_CLRWAIT;
                                end
                            end
                            ST_LINE1: begin
                                if (index_q == 5'd15)
                                    state_d = ST_SETLINE2;
                                else
                                    index_d = index_q + 5'd1;
                            end
                            ST_SETLINE2: begin
                                state_d = ST_LINE2;
                                index_d = 5'd16;
                            end
                            ST_LINE2: begin
                                if (index_q == 5'd31)
                                    state_d = ST_SETLINE1;
                                else
                                    index_d = index_q + 5'd1;
                            end
                            default: begin
                                state_d = ST_LINE1;
                                index_d = 5'd0;
                            end
                        endcase
                    end
                end
                PH_CLRWAIT: begin
                    if (cnt_q == C_CLR_LAST) begin
                        phase_d = PH_FETCH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    phase_d = PH_FETCH;
                    cnt_d   = '0;
                end
            endcase
        end
        en_d   = (state_d != ST_PWRUP) && (phase_d == PH_PULSE);
        done_d = (state_d == ST_SETLINE1) && (phase_d == PH_HOLD) && (cnt_d == C_STEP_LAST);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_PWRUP;
            phase_q    <= PH_FETCH;
            cnt_q      <= '0;
            init_idx_q <= 3'd0;
            index_q    <= 5'd0;
            data_q     <= 8'h00;
            rs_q       <= 1'b0;
            en_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            init_idx_q <= init_idx_d;
            index_q    <= index_d;
            data_q     <= data_d;
            rs_q       <= rs_d;
            en_q       <= en_d;
            done_q     <= done_d;
        end
    end

    assign index      = index_q;
    assign lcd_data   = data_q;
    assign lcd_rs     = rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_en     = en_q;
    assign lcd_on     = 1'b1;
    assign lcd_blon   = 1'b1;
    assign frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_refresh_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lcd_refresh_driver
// Function : Randomised self-checking bench for lcd_refresh_driver against a
//            timeline model of the byte stream.
// Revision : 1.0
// ============================================================================
module tb_lcd_refresh_driver;
    localparam int PW         = 8;
    localparam int SC         = 4;
    localparam int CWT        = 16;
    localparam int BP         = 1 + 3 * SC;
    localparam int CLR_END    = PW + 3 * BP + CWT;
    localparam int LINE_START = PW + 5 * BP + CWT;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic [7:0] char_in = 8'h00;
    logic [4:0] index;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon, frame_done;

    lcd_refresh_driver #(
        .POWERUP_WAIT(PW),
        .STEP_CYCLES (SC),
        .CLEAR_WAIT  (CWT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .char_in   (char_in),
        .index     (index),
        .lcd_data  (lcd_data),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en),
        .lcd_on    (lcd_on),
        .lcd_blon  (lcd_blon),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cur_k    = 0;
    logic [7:0] byte_val [0:511];
    logic       byte_rs  [0:511];
    logic [7:0] init_cmd [0:4];
    logic [7:0] forced_in  [0:5];
    logic [7:0] forced_out [0:5];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cur_k, act, exp);
        end
    endtask

    function automatic logic [7:0] to_ascii(input logic [7:0] c);
        if (c <= 8'd9)       return 8'("0") + c;
        else if (c <= 8'd15) return 8'("A") + (c - 8'd10);
        else                 return c;
    endfunction

    // Maps a cycle count since reset release onto (byte number, offset within byte).
    function automatic void locate(input int k, output int g, output int o);
        if (k < PW) begin
            g = -1; o = k;
        end else if (k < CLR_END) begin
            g = (k - PW) / BP;
            if (g > 2) g = 2;
            o = k - PW - g * BP;
        end else if (k < LINE_START) begin
            g = 3 + (k - CLR_END) / BP;
            o = k - CLR_END - (g - 3) * BP;
        end else begin
            g = 5 + (k - LINE_START) / BP;
            o = (k - LINE_START) % BP;
        end
    endfunction

    task automatic run_phase(input int ph, input int ncyc, input bit stop_mid, output bit hit_mid);
        int g, o, p, cidx, last_fd, en_w, n_rise, rise2;
        bit prev_en, is_char, chk_idx;
        logic [7:0] e_data, c;
        logic e_rs, e_en, e_fd;
        last_fd = -1; en_w = 0; n_rise = 0; rise2 = 0; prev_en = 1'b0; hit_mid = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            if (k > 0) @(negedge clock);
            cur_k = k;
            locate(k, g, o);
            p = (g >= 5) ? (g - 5) % 34 : 0;
            is_char = (g >= 5) && (p != 16) && (p != 33);
            cidx    = (p < 16) ? p : p - 1;
            chk_idx = (g < 5) || is_char;
            if (g < 0) begin
                e_data = 8'h00; e_rs = 1'b0;
            end else if (o == 0) begin
                e_data = (g == 0) ? 8'h00 : byte_val[g-1];
                e_rs   = (g == 0) ? 1'b0  : byte_rs[g-1];
            end else begin
                e_data = byte_val[g]; e_rs = byte_rs[g];
            end
            e_en = (g >= 0) && (o >= 1 + SC) && (o < 1 + 2 * SC);
            e_fd = (g >= 5) && (p == 33) && (o == BP - 1);

            check("lcd_data", int'(lcd_data), int'(e_data));
            check("lcd_rs", int'(lcd_rs), int'(e_rs));
            check("lcd_en", int'(lcd_en), int'(e_en));
            check("frame_done", int'(frame_done), int'(e_fd));
            check("fixed_pins", int'({lcd_rw, lcd_on, lcd_blon}), 3);
            if (chk_idx) check("index", int'(index), (g < 5) ? 0 : cidx);
            if (ph == 1 && g >= 5 && g <= 10 && o == 1)
                check("hex_literal", int'(lcd_data), int'(forced_out[g-5]));

            if (lcd_en && !prev_en) begin
                n_rise++;
                if (n_rise == 3) rise2 = k;
                if (n_rise == 4) check("clear_gap", k - rise2, 29);
            end
            if (lcd_en) en_w++;
            if (!lcd_en && prev_en) begin
                check("en_width", en_w, 4);
                en_w = 0;
            end
            prev_en = lcd_en;
            if (frame_done) begin
                if (last_fd >= 0) check("frame_period", k - last_fd, 442);
                last_fd = k;
            end

            if (g >= 0 && o == 0) begin
                char_in = 8'($urandom);
                if (g < 5) begin
                    byte_val[g] = init_cmd[g]; byte_rs[g] = 1'b0;
                end else if (!is_char) begin
                    byte_val[g] = (p == 16) ? 8'hC0 : 8'h80; byte_rs[g] = 1'b0;
                end else begin
                    if (ph == 1 && g <= 10)
                        c = forced_in[g-5];
                    else if ($urandom_range(0, 2) == 0)
                        c = 8'($urandom);
                    else
                        c = 8'($urandom_range(0, 15));
                    char_in = c;
                    byte_val[g] = to_ascii(c); byte_rs[g] = 1'b1;
                end
            end else begin
                char_in = 8'($urandom);
            end

            if (stop_mid && k >= 1000 && g >= 5 && o == 2 + SC) begin
                hit_mid = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit hit;
        init_cmd[0] = 8'h38; init_cmd[1] = 8'h0C; init_cmd[2] = 8'h01;
        init_cmd[3] = 8'h06; init_cmd[4] = 8'h80;
        forced_in[0]  = 8'h03; forced_in[1]  = 8'h0A; forced_in[2]  = 8'h4F;
        forced_in[3]  = 8'h09; forced_in[4]  = 8'h0F; forced_in[5]  = 8'h10;
        forced_out[0] = 8'h33; forced_out[1] = 8'h41; forced_out[2] = 8'h4F;
        forced_out[3] = 8'h39; forced_out[4] = 8'h46; forced_out[5] = 8'h10;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        run_phase(1, 1100, 1'b1, hit);
        check("mid_pulse_reached", int'(hit), 1);

        // Reset lands while the enable strobe is high.
        #1 reset = 1'b1;
        #1;
        cur_k = -1;
        check("async_rst_en", int'(lcd_en), 0);
        check("async_rst_rs", int'(lcd_rs), 0);
        check("async_rst_index", int'(index), 0);
        check("async_rst_data", int'(lcd_data), 0);
        check("async_rst_fd", int'(frame_done), 0);
        @(negedge clock);
        check("held_rst_en", int'(lcd_en), 0);
        @(negedge clock);
        reset = 1'b0;
        run_phase(2, 250, 1'b0, hit);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
